// File: rtl/axis_fft_bin_serializer.sv
// Splits one 512-bit beat of eight complex DFT bins into eight 64-bit beats, bin 0 first.
// A hold register feeds the output mux and a pending buffer absorbs the next frame.
module axis_fft_bin_serializer #(
    parameter int C_AXIS_TIN_WIDTH   = 512,
    parameter int C_AXIS_TDATA_WIDTH = 64,
    parameter int C_SAMPLE_WIDTH     = 32,
    parameter int C_FRAME_CNT_WIDTH  = 16
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic [C_AXIS_TIN_WIDTH-1:0]   s_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tlast,
    output logic [2:0]                    m_axis_tuser,
    output logic [C_FRAME_CNT_WIDTH-1:0]  frame_count
);

    localparam int unsigned BEAT_W = 2 * C_SAMPLE_WIDTH;

    // Handshakes: a beat transfers on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a presented beat stays stable until it transfers.
    logic [C_AXIS_TIN_WIDTH-1:0]  r_hold;
    logic [C_AXIS_TIN_WIDTH-1:0]  r_pend;
    logic                         r_hold_valid;
    logic                         r_p_valid;
    logic [2:0]                   r_cnt;
    logic                         r_s_tready;
    logic [C_FRAME_CNT_WIDTH-1:0] r_frame_count;

    logic w_s_fire;
    logic w_m_fire;
    logic w_last_fire;
    logic w_p_valid_nxt;

    assign w_s_fire    = s_axis_tvalid & r_s_tready;
    assign w_m_fire    = r_hold_valid & m_axis_tready;
    assign w_last_fire = w_m_fire & (r_cnt == 3'd7);

    // P only fills when H is busy and not handing off; a bin-7 handoff always empties it.
    assign w_p_valid_nxt = w_last_fire ? 1'b0 : (r_p_valid | (w_s_fire & r_hold_valid));

    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_areset) begin
            r_hold        <= '0;
            r_hold_valid  <= 1'b0;
            r_p_valid     <= 1'b0;
            r_cnt         <= 3'd0;
            r_s_tready    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_p_valid  <= w_p_valid_nxt;
            r_s_tready <= ~w_p_valid_nxt;
            if (w_last_fire) begin
                r_frame_count <= r_frame_count + 1'b1;
                r_cnt         <= 3'd0;
                if (r_p_valid) begin
                    r_hold <= r_pend;
                end else if (w_s_fire) begin
                    r_hold <= s_axis_tdata;
                end else begin
                    r_hold_valid <= 1'b0;
                end
            end else begin
                if (w_m_fire) begin
                    r_cnt <= r_cnt + 3'd1;
                end
                if (w_s_fire) begin
                    if (!r_hold_valid) begin
                        r_hold       <= s_axis_tdata;
                        r_hold_valid <= 1'b1;
                        r_cnt        <= 3'd0;
                    end else begin
                        r_pend <= s_axis_tdata;
                    end
                end
            end
        end
    end

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_hold_valid;
    assign m_axis_tdata  = r_hold[32'(r_cnt) * BEAT_W +: BEAT_W];
    assign m_axis_tuser  = r_cnt;
    assign m_axis_tlast  = (r_cnt == 3'd7);
    assign frame_count   = r_frame_count;

endmodule

// File: tb/tb_axis_fft_bin_serializer.sv
// Bench for axis_fft_bin_serializer: vector table, back-to-back burst, random stalls,
// mid-frame reset and frame counter wrap (on a 4-bit-counter instance).
module tb_axis_fft_bin_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         areset;
    logic         s_tvalid;
    logic         s_tready;
    logic [511:0] s_tdata;
    logic         m_tvalid;
    logic         m_tready;
    logic [63:0]  m_tdata;
    logic         m_tlast;
    logic [2:0]   m_tuser;
    logic [15:0]  frame_count;

    logic         w4_s_tready;
    logic         w4_m_tvalid;
    logic [63:0]  w4_m_tdata;
    logic         w4_m_tlast;
    logic [2:0]   w4_m_tuser;
    logic [3:0]   w4_frame_count;

    axis_fft_bin_serializer u_dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (areset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tuser  (m_tuser),
        .frame_count   (frame_count)
    );

    axis_fft_bin_serializer #(.C_FRAME_CNT_WIDTH(4)) u_dut_w4 (
        .s_axis_aclk   (clk),
        .s_axis_areset (areset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (w4_s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (w4_m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (w4_m_tdata),
        .m_axis_tlast  (w4_m_tlast),
        .m_axis_tuser  (w4_m_tuser),
        .frame_count   (w4_frame_count)
    );

    typedef struct {
        logic [511:0]     frame;
        logic [7:0][63:0] exp;
        logic [15:0]      exp_fc;
    } vec_t;

    vec_t        vecs[4];
    logic [67:0] exp_q[$];
    int          exp_frames = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          mon_en = 1'b0;
    bit          tready_rand = 1'b0;
    bit          stalled = 1'b0;
    logic [67:0] stall_snap;

    task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] pack(input logic [7:0][31:0] re, input logic [7:0][31:0] im);
        logic [511:0] f;
        for (int k = 0; k < 8; k++) begin
            f[64*k+32 +: 32] = re[k];
            f[64*k    +: 32] = im[k];
        end
        return f;
    endfunction

    // Monitor: sampled on the falling edge, so the values seen are the ones the next rising edge uses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (stalled) begin
                chk("stall_valid", 68'(m_tvalid), 68'(1));
                chk("stall_hold", {m_tdata, m_tuser, m_tlast}, stall_snap);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {m_tdata, m_tuser, m_tlast}, 68'(0));
                end else begin
                    logic [67:0] e;
                    e = exp_q.pop_front();
                    chk("beat", {m_tdata, m_tuser, m_tlast}, e);
                    if (e[0]) exp_frames++;
                end
            end
            stalled    = m_tvalid && !m_tready;
            stall_snap = {m_tdata, m_tuser, m_tlast};
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = tready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic send_frame(input logic [511:0] f, input logic [7:0][63:0] e);
        int t = 0;
        @(negedge clk);
        s_tvalid = 1'b1;
        s_tdata  = f;
        while (!s_tready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!s_tready) begin
            chk("send_timeout", 68'(s_tready), 68'(1));
            s_tvalid = 1'b0;
            return;
        end
        for (int k = 0; k < 8; k++) exp_q.push_back({e[k], 3'(k), k == 7});
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic send_rand();
        logic [7:0][31:0] re;
        logic [7:0][31:0] im;
        logic [7:0][63:0] e;
        for (int k = 0; k < 8; k++) begin
            re[k] = $urandom;
            im[k] = $urandom;
            e[k]  = {re[k], im[k]};
        end
        send_frame(pack(re, im), e);
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk(name, 68'(exp_q.size()), 68'(0));
        repeat (3) @(negedge clk);
    endtask

    // Called at a falling edge: reset for two edges, check cleared outputs, release.
    task automatic do_reset();
        s_tvalid = 1'b0;
        areset   = 1'b0;
        mon_en   = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_m_tvalid", 68'(m_tvalid), 68'(0));
        chk("rst_m_tlast", 68'(m_tlast), 68'(0));
        chk("rst_m_tuser", 68'(m_tuser), 68'(0));
        chk("rst_m_tdata", 68'(m_tdata), 68'(0));
        chk("rst_frame_count", 68'(frame_count), 68'(0));
        chk("rst_s_tready", 68'(s_tready), 68'(0));
        exp_q.delete();
        exp_frames = 0;
        @(posedge clk);
        @(negedge clk);
        areset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_s_tready", 68'(s_tready), 68'(1));
        chk("post_rst_m_tvalid", 68'(m_tvalid), 68'(0));
        mon_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0][31:0] re;
        logic [7:0][31:0] im;
        int gaps;
        int low_cnt;
        int t;

        areset   = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;

        for (int k = 0; k < 8; k++) begin
            re[k] = 32'd1;
            im[k] = 32'd0;
            vecs[0].exp[k] = 64'h0000_0001_0000_0000;
        end
        vecs[0].frame  = pack(re, im);
        vecs[0].exp_fc = 16'd1;
        for (int k = 0; k < 8; k++) begin
            re[k] = 32'(k + 1);
            im[k] = 32'(-(k + 1));
            vecs[1].exp[k] = {32'(k + 1), 32'hFFFF_FFFF - 32'(k)};
        end
        vecs[1].frame  = pack(re, im);
        vecs[1].exp_fc = 16'd2;
        for (int v = 2; v < 4; v++) begin
            for (int k = 0; k < 8; k++) begin
                re[k] = $urandom;
                im[k] = $urandom;
                vecs[v].exp[k] = {re[k], im[k]};
            end
            vecs[v].frame  = pack(re, im);
            vecs[v].exp_fc = 16'(v + 1);
        end

        repeat (2) @(negedge clk);
        do_reset();

        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].frame, vecs[v].exp);
            drain("vec_drain");
            chk("vec_frame_count", 68'(frame_count), 68'(vecs[v].exp_fc));
        end

        // Three frames back to back: 24 gapless beats, s_tready low only while P holds a frame.
        fork
            begin
                repeat (3) send_rand();
            end
        join_none
        t = 0;
        @(negedge clk);
        while (!m_tvalid && t < 50) begin
            @(negedge clk);
            t++;
        end
        gaps    = 0;
        low_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            if (!m_tvalid) gaps++;
            if (!s_tready) low_cnt++;
            @(negedge clk);
        end
        wait fork;
        chk("b2b_gaps", 68'(gaps), 68'(0));
        chk("b2b_s_tready_low", 68'(low_cnt), 68'(14));
        drain("b2b_drain");
        chk("b2b_frame_count", 68'(frame_count), 68'(7));

        tready_rand = 1'b1;
        repeat (4) send_rand();
        drain("stall_drain");
        tready_rand = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_frame_count", 68'(frame_count), 68'(11));

        // Reset at bin 3 of a frame while the next frame sits in P.
        send_rand();
        send_rand();
        t = 0;
        @(negedge clk);
        while (!(m_tvalid && m_tuser == 3'd3) && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("reach_bin3", 68'(m_tuser), 68'(3));
        do_reset();
        send_rand();
        drain("after_rst_drain");
        chk("after_rst_frame_count", 68'(frame_count), 68'(1));

        @(negedge clk);
        do_reset();
        repeat (15) send_rand();
        drain("wrap_pre_drain");
        chk("wrap_pre_w4", 68'(w4_frame_count), 68'(4'hF));
        chk("wrap_pre_main", 68'(frame_count), 68'(15));
        send_rand();
        drain("wrap_drain");
        chk("wrap_w4", 68'(w4_frame_count), 68'(0));
        chk("wrap_main", 68'(frame_count), 68'(16));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_fft_bin_serializer.md
Name: axis_fft_bin_serializer

Overview:
Downstream neighbour of the 8-point DFT stage. It accepts one 512-bit AXI-Stream beat holding all eight complex bins (16 x 32-bit signed) and emits them as eight 64-bit AXI-Stream beats, bin 0 first, with tlast on bin 7. It double-buffers so that back-to-back frames stream at one bin per cycle with no bubble, which feeds the 64-bit DMA/egress path.

Parameters:
C_AXIS_TIN_WIDTH, 512, input data width; fixed at 16 x C_SAMPLE_WIDTH
C_AXIS_TDATA_WIDTH, 64, output data width; fixed at 2 x C_SAMPLE_WIDTH
C_SAMPLE_WIDTH, 32, width of each real or imaginary component
C_FRAME_CNT_WIDTH, 16, width of the completed-frame counter

Ports:
s_axis_aclk  in  1  sole clock
s_axis_areset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of s_axis_aclk)
s_axis_tvalid  in  1  input frame valid
s_axis_tready  out  1  input frame accepted when high with tvalid
s_axis_tdata  in  512  bin k real at [64k+63:64k+32], bin k imag at [64k+31:64k], k=0..7
m_axis_tvalid  out  1  output bin valid
m_axis_tready  in  1  downstream ready
m_axis_tdata  out  64  {real[63:32], imag[31:0]} of current bin
m_axis_tlast  out  1  high on bin 7 of each frame
m_axis_tuser  out  3  bin index of current beat
frame_count  out  C_FRAME_CNT_WIDTH  number of frames whose bin 7 has been accepted downstream

Behaviour:
- State: hold register H (512 b), hold_valid, bin counter cnt (3 b), out_valid; optional pending buffer P (512 b) with p_valid.
- Reset (s_axis_areset==0 at a clock edge): m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, cnt=0, hold_valid=0, p_valid=0, frame_count=0. s_axis_tready is low during reset and high on the first cycle after reset.
- s_axis_tready = ~p_valid. It is a pure register output and has no combinational path from m_axis_tready.
- Input accept (s_tvalid & s_tready):
  - If H is empty, or H is on bin 7 being accepted this cycle, the beat loads H directly and cnt becomes 0.
  - Otherwise the beat loads P and p_valid=1.
- On a bin-7 handshake, if p_valid=1, P moves into H, cnt=0, and p_valid clears in the same cycle. There is no idle cycle between frames.
- Latency: a frame accepted at edge N presents bin 0 with m_axis_tvalid=1 after edge N when H was empty.
- Output mux: m_axis_tdata = H[64*cnt+63 : 64*cnt]. m_axis_tuser = cnt. m_axis_tlast = (cnt==7). m_axis_tvalid = hold_valid.
- Output handshake (m_tvalid & m_tready): cnt increments. At cnt==7, cnt wraps to 0, frame_count increments (wraps at 2^C_FRAME_CNT_WIDTH), and H reloads from P or from the input, or hold_valid clears if neither is available.
- AXI rules: while m_tvalid=1 and m_tready=0, tdata, tuser and tlast hold stable. m_tvalid never drops without a handshake except on reset.
- Data passes through untouched: no rounding, sign change or reordering inside a 64-bit beat.
- Simultaneous events:
  - Input accept during the bin-7 handshake with P empty: the input loads H and the next frame's bin 0 follows immediately.
  - Input accept while H is busy and P is empty: the input goes to P.
  - With P full, s_tready=0 and the input is stalled.
- Reset mid-frame: the remaining bins and P are discarded. frame_count does not count the partial frame.
- Sustained throughput: 1 frame per 8 cycles when m_tready is held high.

Test Plan:
- Impulse frame (every bin real=0x00000001, imag=0), m_tready=1 -> 8 beats of tdata 0x0000000100000000, tuser 0..7, tlast only on beat 7, frame_count=1.
- Ramp frame (bin k real=k+1, imag=-(k+1)) -> beat k tdata {k+1, 32'hFFFFFFFF-k}, correct order, no byte swap.
- Three back-to-back frames with m_tready=1 -> 24 consecutive valid beats with no gaps. s_tready goes low only while P is full. frame_count=3.
- m_tready toggled 1-0-0-1 at random -> tdata, tuser and tlast stable during stalls, no beat lost or duplicated, bin order preserved across 4 frames.
- s_axis_areset=0 asserted at bin 3 of frame 1 with frame 2 in P -> next cycle m_tvalid=0, frame_count=0. The first frame after reset starts at bin 0 with fresh data.
- frame_count driven to 0xFFFF then one more frame -> frame_count wraps to 0x0000.
